// File: rtl/exec_seq_pkg.sv
// Shared definitions for the instruction sequencer: state encodings reused by
// the control unit and the debug trace.
package exec_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5,
        ERR   = 3'd6
    } seq_state_t;

    // States that wait on an external bus pulse and are policed by the watchdog.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == FETCH) || (s == MEM);
    endfunction

endpackage

// File: rtl/exec_sequencer_watchdog.sv
// Cycle counter that flags a bus wait lasting TIMEOUT cycles without the
// awaited pulse.
module seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Expiry is combinational on the count so the FSM can still let a
    // same-cycle completion pulse take priority.
    assign expired = count_en && (count_reg == LIMIT);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_en && !expired) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute/memory/write-back sequencer with retired-instruction
// counter and bus watchdog trap.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ifu_req,
    input  logic               ifu_valid,
    output logic               instr_latch_en,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               is_ebreak,
    input  logic               reg_wen_in,
    output logic               lsu_req,
    input  logic               lsu_done,
    output logic               rf_wen,
    output logic               pc_wen,
    output logic [CNT_W-1:0]   instret,
    output logic               halted,
    output logic               bus_err,
    output logic [STATE_W-1:0] state_o
);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [CNT_W-1:0] instret_reg;
    logic [CNT_W-1:0] instret_next;
    logic             wd_clear;
    logic             wd_count_en;
    logic             wd_expired;

    assign wd_clear    = (state_next != state_reg);
    assign wd_count_en = is_wait_state(state_reg);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:  state_next = FETCH;
            FETCH: begin
                if (ifu_valid) begin
                    state_next = EXEC;
                end else if (wd_expired) begin
                    state_next = ERR;
                end
            end
            EXEC: begin
                // ebreak outranks a memory decode so no LSU request is issued for it.
                if (is_ebreak) begin
                    state_next = HALT;
                end else if (is_load || is_store) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (lsu_done) begin
                    state_next = WB;
                end else if (wd_expired) begin
                    state_next = ERR;
                end
            end
            WB:    state_next = FETCH;
            HALT:  state_next = HALT;
            ERR:   state_next = ERR;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        ifu_req        = 1'b0;
        instr_latch_en = 1'b0;
        lsu_req        = 1'b0;
        rf_wen         = 1'b0;
        pc_wen         = 1'b0;
        halted         = 1'b0;
        bus_err        = 1'b0;
        instret_next   = instret_reg;
        case (state_reg)
            FETCH: begin
                ifu_req        = 1'b1;
                instr_latch_en = ifu_valid;
            end
            MEM:  lsu_req = 1'b1;
            WB: begin
                rf_wen       = reg_wen_in;
                pc_wen       = 1'b1;
                instret_next = instret_reg + CNT_W'(1);
            end
            HALT: halted  = 1'b1;
            ERR:  bus_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= BOOT;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            instret_reg <= instret_next;
        end
    end

    assign instret = instret_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: vector table for the main instruction flow
// plus hand-written multi-cycle sequences (LSU latency, ebreak, watchdog, reset).
module tb_exec_sequencer;

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n, ifu_valid, is_load, is_store, is_ebreak, reg_wen_in, lsu_done;
    logic        ifu_req, instr_latch_en, lsu_req, rf_wen, pc_wen, halted, bus_err;
    logic [63:0] instret;
    logic [2:0]  state_o;
    logic        wd_ifu_req, wd_instr_latch_en, wd_lsu_req, wd_rf_wen, wd_pc_wen;
    logic        wd_halted, wd_bus_err;
    logic [63:0] wd_instret;
    logic [2:0]  wd_state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.TIMEOUT(255), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_valid(ifu_valid),
        .instr_latch_en(instr_latch_en), .is_load(is_load), .is_store(is_store),
        .is_ebreak(is_ebreak), .reg_wen_in(reg_wen_in), .lsu_req(lsu_req),
        .lsu_done(lsu_done), .rf_wen(rf_wen), .pc_wen(pc_wen), .instret(instret),
        .halted(halted), .bus_err(bus_err), .state_o(state_o)
    );

    exec_sequencer #(.TIMEOUT(4), .CNT_W(64)) dut_wd (
        .clk(clk), .rst_n(rst_n), .ifu_req(wd_ifu_req), .ifu_valid(ifu_valid),
        .instr_latch_en(wd_instr_latch_en), .is_load(is_load), .is_store(is_store),
        .is_ebreak(is_ebreak), .reg_wen_in(reg_wen_in), .lsu_req(wd_lsu_req),
        .lsu_done(lsu_done), .rf_wen(wd_rf_wen), .pc_wen(wd_pc_wen), .instret(wd_instret),
        .halted(wd_halted), .bus_err(wd_bus_err), .state_o(wd_state_o)
    );

    typedef struct {
        logic [6:0]  in;     // {rst_n, ifu_valid, is_load, is_store, is_ebreak, reg_wen_in, lsu_done}
        logic [2:0]  st;
        logic [6:0]  flags;  // {ifu_req, instr_latch_en, lsu_req, rf_wen, pc_wen, halted, bus_err}
        logic [63:0] cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input logic ld, input logic st,
                       input logic eb, input logic rw, input logic dn);
        @(negedge clk);
        rst_n = r; ifu_valid = iv; is_load = ld; is_store = st;
        is_ebreak = eb; reg_wen_in = rw; lsu_done = dn;
        #1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  cnt;
        logic done, seen_lsu, seen_pc, seen_rf, all_halt;

        rst_n = 0; ifu_valid = 0; is_load = 0; is_store = 0;
        is_ebreak = 0; reg_wen_in = 0; lsu_done = 0;

        // ALU op, store with one LSU wait, ALU op with fetch wait and stray pulses.
        vecs[0]  = '{7'b1000000, S_BOOT,  7'b0000000, 64'd0};
        vecs[1]  = '{7'b1100010, S_FETCH, 7'b1100000, 64'd0};
        vecs[2]  = '{7'b1000010, S_EXEC,  7'b0000000, 64'd0};
        vecs[3]  = '{7'b1000010, S_WB,    7'b0001100, 64'd0};
        vecs[4]  = '{7'b1100000, S_FETCH, 7'b1100000, 64'd1};
        vecs[5]  = '{7'b1001000, S_EXEC,  7'b0000000, 64'd1};
        vecs[6]  = '{7'b1000000, S_MEM,   7'b0010000, 64'd1};
        vecs[7]  = '{7'b1000001, S_MEM,   7'b0010000, 64'd1};
        vecs[8]  = '{7'b1000001, S_WB,    7'b0000100, 64'd1};
        vecs[9]  = '{7'b1000000, S_FETCH, 7'b1000000, 64'd2};
        vecs[10] = '{7'b1100000, S_FETCH, 7'b1100000, 64'd2};
        vecs[11] = '{7'b1100000, S_EXEC,  7'b0000000, 64'd2};
        vecs[12] = '{7'b1000011, S_WB,    7'b0001100, 64'd2};
        vecs[13] = '{7'b1000000, S_FETCH, 7'b1000000, 64'd3};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].in[6], vecs[i].in[5], vecs[i].in[4], vecs[i].in[3],
                vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
            $display("vec %0d: in=%b state=%0d flags=%b instret=%0d", i, vecs[i].in,
                     state_o, {ifu_req, instr_latch_en, lsu_req, rf_wen, pc_wen, halted, bus_err},
                     instret);
            chk($sformatf("vec%0d_state", i), 64'(state_o), 64'(vecs[i].st));
            chk($sformatf("vec%0d_flags", i),
                64'({ifu_req, instr_latch_en, lsu_req, rf_wen, pc_wen, halted, bus_err}),
                64'(vecs[i].flags));
            chk($sformatf("vec%0d_instret", i), instret, vecs[i].cnt);
        end

        // Load: lsu_done arrives 5 cycles after MEM entry.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 1, 0);
        chk("load_exec", 64'(state_o), 64'(S_EXEC));
        cnt = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            cyc(1, 0, 0, 0, 0, 1, logic'(c == 5));
            if (lsu_req) cnt++;
            if (state_o == S_WB) done = 1;
        end
        $display("load: lsu_req cycles=%0d state=%0d", cnt, state_o);
        chk("load_wb_reached", 64'(done), 64'd1);
        chk("load_lsu_req_cycles", 64'(cnt), 64'd6);
        chk("load_wb_rf_pc", 64'({rf_wen, pc_wen}), 64'b11);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("load_instret", instret, 64'd1);
        chk("load_back_fetch", 64'(state_o), 64'(S_FETCH));

        // ebreak with load decode: HALT, no LSU request, no retire.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 1, 0);
        seen_lsu = lsu_req; seen_pc = pc_wen; seen_rf = rf_wen; all_halt = 1;
        for (int c = 0; c < 8; c++) begin
            cyc(1, logic'(c % 2), 1, 0, 1, 1, 1);
            seen_lsu |= lsu_req; seen_pc |= pc_wen; seen_rf |= rf_wen;
            all_halt &= halted && (state_o == S_HALT);
        end
        $display("ebreak: state=%0d halted=%b lsu_seen=%b pc_seen=%b", state_o, halted, seen_lsu, seen_pc);
        chk("ebreak_halt_held", 64'(all_halt), 64'd1);
        chk("ebreak_no_lsu_req", 64'(seen_lsu), 64'd0);
        chk("ebreak_no_pc_rf", 64'({seen_pc, seen_rf}), 64'd0);
        chk("ebreak_instret", instret, 64'd0);
        do_reset();
        chk("ebreak_reset_clears", 64'({halted, state_o}), 64'(S_BOOT));

        // Watchdog TIMEOUT=4: fetch never answered.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            if (wd_state_o != S_FETCH) break;
            cnt++;
        end
        $display("watchdog: fetch cycles=%0d state=%0d bus_err=%b", cnt, wd_state_o, wd_bus_err);
        chk("wd_fetch_cycles", 64'(cnt), 64'd4);
        chk("wd_err_state", 64'(wd_state_o), 64'(S_ERR));
        chk("wd_bus_err", 64'(wd_bus_err), 64'd1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("wd_err_holds", 64'({wd_bus_err, wd_state_o}), 64'({1'b1, S_ERR}));

        // Watchdog TIMEOUT=4: ifu_valid on the expiring 4th cycle wins.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc(1, logic'(c == 3), 0, 0, 0, 0, 0);
        chk("wd_late_fetch_latch", 64'({wd_state_o, wd_instr_latch_en}), 64'({S_FETCH, 1'b1}));
        cyc(1, 0, 0, 0, 0, 0, 0);
        $display("watchdog late pulse: state=%0d bus_err=%b", wd_state_o, wd_bus_err);
        chk("wd_late_exec", 64'(wd_state_o), 64'(S_EXEC));
        chk("wd_late_no_err", 64'(wd_bus_err), 64'd0);

        // Reset asserted mid-MEM after one retired instruction.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rstmem_pre_state", 64'({state_o, lsu_req}), 64'({S_MEM, 1'b1}));
        chk("rstmem_pre_instret", instret, 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        $display("reset mid-MEM: state=%0d lsu_req=%b instret=%0d", state_o, lsu_req, instret);
        chk("rstmem_state_boot", 64'(state_o), 64'(S_BOOT));
        chk("rstmem_outputs_zero",
            64'({ifu_req, instr_latch_en, lsu_req, rf_wen, pc_wen, halted, bus_err}), 64'd0);
        chk("rstmem_instret_zero", instret, 64'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rstmem_release_boot", 64'(state_o), 64'(S_BOOT));
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rstmem_then_fetch", 64'({state_o, ifu_req}), 64'({S_FETCH, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control sequencer for the RV64 core: steps each instruction through fetch, execute, memory and write-back. It drives the IFU fetch request and the LSU request, gates register-file write-back and PC update to one cycle per instruction, and counts retired instructions. A watchdog traps hung bus transactions. It sits between the control unit, the IFU/LSU AXI4 masters, the PC register and the register file.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles in FETCH or MEM before an error trap; legal range ≥1.
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ifu_req  out  1  fetch request to the IFU at the current PC; level signal.
- ifu_valid  in  1  IFU instruction returned; one-cycle pulse.
- instr_latch_en  out  1  loads the instruction register.
- is_load  in  1  CU decode of the latched instruction; sampled in EXEC.
- is_store  in  1  CU decode; sampled in EXEC.
- is_ebreak  in  1  CU decode; sampled in EXEC.
- reg_wen_in  in  1  CU RegWriteEnable; sampled in WB.
- lsu_req  out  1  memory access request; level signal.
- lsu_done  in  1  LSU completion; one-cycle pulse.
- rf_wen  out  1  gated register-file write enable.
- pc_wen  out  1  PC register update enable.
- instret  out  CNT_W  retired-instruction count.
- halted  out  1  ebreak reached.
- bus_err  out  1  watchdog trap.
- state_o  out  3  current state encoding, for debug.

## Operation
States and encodings: BOOT=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- BOOT: all outputs 0. Always moves to FETCH after one cycle.
- FETCH: ifu_req=1.
  - If ifu_valid: instr_latch_en=1 in that same cycle (Mealy output), then go to EXEC.
  - Else, if the watchdog expires: go to ERR.
- EXEC: exactly one cycle. Priority order for the next state:
  - is_ebreak → HALT.
  - else is_load|is_store → MEM.
  - else → WB.
- MEM: lsu_req=1. On lsu_done go to WB; on watchdog expiry go to ERR.
- WB: exactly one cycle. rf_wen=reg_wen_in, pc_wen=1, instret increments by 1 (wraps modulo 2^CNT_W). Then go to FETCH.
- HALT: halted=1; holds until reset. No PC update and no instret increment for the ebreak.
- ERR: bus_err=1; holds until reset.

Watchdog:
- Clears on every state change.
- Counts cycles while in FETCH or MEM.
- Expires when the count reaches TIMEOUT−1 without the awaited pulse.

Boundary rules:
- Awaited pulse (ifu_valid or lsu_done) arrives in the same cycle the watchdog expires: the pulse wins, no error.
- ifu_valid outside FETCH and lsu_done outside MEM: ignored.
- is_ebreak together with is_load or is_store: HALT; lsu_req is never asserted.
- Unused states 7: go to BOOT.

## Timing
- Reset: on any edge with rst_n=0, state becomes BOOT. instret=0 and every output is 0 from that edge on, including mid-MEM or mid-FETCH. A pending bus transaction is abandoned; the AXI masters are reset together with the sequencer.
- All outputs except instr_latch_en are Moore outputs, decoded from registered state. instr_latch_en is combinational from ifu_valid.
- ifu_req and lsu_req stay high continuously until the cycle of their completion pulse. They drop on the following edge.
- Minimum latency per instruction:
  - Non-memory instruction: 3 cycles (FETCH with immediate ifu_valid, EXEC, WB).
  - Load/store: 4 cycles.
  - Each wait cycle adds 1.
- rf_wen and pc_wen are each high for exactly one cycle per retired instruction.

## Structure
- Package exec_seq_pkg holds the state typedef and encodings (BOOT..ERR) and a STATE_W=3 constant. The CU and debug trace reuse it.
- Sub-module seq_watchdog holds the cycle counter, width $clog2(TIMEOUT+1). Its ports are clear, count-enable and expired.
- instret register and FSM live in exec_sequencer.

## Test plan
- Reset then ALU op:
  - Stimulus: rst_n low 2 cycles, then high; ifu_valid in the first FETCH cycle; no decode flags; reg_wen_in=1.
  - Required: states BOOT,FETCH,EXEC,WB,FETCH; rf_wen=1 and pc_wen=1 for one cycle; instret=1.
- Load with LSU latency:
  - Stimulus: is_load=1; lsu_done 5 cycles after MEM entry.
  - Required: lsu_req high exactly 6 cycles, then WB; instret increments by 1.
- Store:
  - Stimulus: is_store=1, reg_wen_in=0.
  - Required: rf_wen stays 0 and pc_wen pulses once.
- ebreak:
  - Stimulus: is_ebreak=1 together with is_load=1.
  - Required: HALT; lsu_req never asserted; pc_wen=0; instret unchanged; halted=1 until reset.
- Watchdog with TIMEOUT=4:
  - Stimulus: ifu_valid never arrives.
  - Required: ERR after 4 FETCH cycles, bus_err=1.
  - Rerun with ifu_valid on the 4th cycle: EXEC, no error.
- Reset mid-MEM:
  - Stimulus: rst_n low during MEM.
  - Required: lsu_req=0 and instret=0 from that edge; BOOT then FETCH after release.
